seq_mag_compare: RTL and testbench
==================================

// Module: seq_mag_compare
// PURPOSE
//  Parametrised, multi-cycle, cascadable magnitude comparator (successor of the 4-bit combinational compare slice).
//  Compares two WIDTH-bit operands MSB-first, SLICE bits per cycle, with early termination and optional two's-complement mode.
//  Equal operands resolve to the one-hot cascade input from a less-significant stage.
//  Sits between operand producers and control logic on a valid/ready stream.
// PARAMETERS
//  WIDTH  16  operand width; must be a multiple of SLICE (elaboration error otherwise)
//  SLICE  4   bits compared per cycle; NSLICE = WIDTH/SLICE
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  in_valid     in   1      operand/command valid
//  in_ready     out  1      block can accept; transfer on in_valid & in_ready
//  in_a         in   WIDTH  operand A
//  in_b         in   WIDTH  operand B
//  in_signed    in   1      1 = two's-complement compare, 0 = unsigned
//  in_casc_lt   in   1      cascade input: lower stage says A<B
//  in_casc_eq   in   1      cascade input: lower stage says A==B
//  in_casc_gt   in   1      cascade input: lower stage says A>B
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  out_lt/eq/gt out  1 each one-hot result (A<B, A==B, A>B)
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, out_valid=0, out_lt/eq/gt=0, in_ready=0 while rst high.
//    Any in-flight compare is dropped, and nothing is emitted for it.
//  - FSM IDLE -> RUN -> DONE.
//    IDLE: in_ready=1; an accepted transfer latches a, b, signed and cascade, sets idx=NSLICE-1, and goes to RUN.
//    RUN: in_ready=0; compares slice idx of the latched operands.
//      Slices differ: load lt/gt result and go to DONE.
//      Slices equal and idx==0: load cascade result and go to DONE.
//      Otherwise: idx-1, stay in RUN.
//    DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
//      If in_valid is also high, accept the new operands that same cycle (in_ready = out_ready in DONE) and go straight to RUN.
//  - Latency: out_valid rises k cycles after the accept edge; k = 1 + number of equal leading slices, 1<=k<=NSLICE.
//    Throughput: one result per k+1 cycles, with back-to-back accept from DONE.
//  - Signed mode: invert the top bit of both operands in the top slice before the unsigned compare.
//  - Cascade decode (not required one-hot): eq has priority, then gt, then lt. All-zero decodes as eq.
//  - Outputs are registered. out_lt/eq/gt are exactly one-hot whenever out_valid=1, and all 0 after reset until the first result.
//  - in_valid while RUN: ignored (in_ready=0). The producer must hold operands stable until the transfer.
//  - out_ready while out_valid=0: no effect.
// STRUCTURE
//  - Package cmp_pkg: state enum {IDLE,RUN,DONE}; result typedef cmp_res_t {lt,eq,gt}; function decoding the cascade to cmp_res_t.
//  - Sub-module cmp_slice #(SLICE): combinational SLICE-bit unsigned compare -> lt/eq/gt; instantiated once, fed by an idx-selected mux.
//  - Top level: operand registers, idx counter ($clog2(NSLICE) bits, min 1), FSM, result register.
// TESTING (WIDTH=16, SLICE=4)
//  1. a=0x1234, b=0x1234, unsigned, casc_gt=1 -> out_gt=1, valid 4 cycles after accept.
//  2. a=0x8000, b=0x7FFF, unsigned -> out_gt=1, latency 1; same operands with in_signed=1 -> out_lt=1, latency 1.
//  3. a=0x0001, b=0x0002, unsigned -> out_lt=1, latency 4; a=0xFFFF, b=0x0000, signed -> out_lt=1, latency 1.
//  4. Backpressure: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0.
//     Then out_ready=1 with in_valid=1 in the same cycle -> new transfer accepted, next result correct.
//  5. Assert rst during the 2nd RUN cycle of case 1 -> out_valid=0 and outputs 0 immediately; a fresh compare after release is correct.
//  6. Cascade all-zero with a==b -> out_eq=1. Cascade lt=gt=1, eq=0 with a==b -> out_gt=1.

Source files
------------

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared types and helpers for the sequential magnitude
//                comparator: FSM state encoding, one-hot result type and
//                cascade-input decoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_res_t;

  // Cascade inputs need not be one-hot: eq wins, then gt, then lt.
  // An all-zero cascade means the lower stage has nothing to say -> equal.
  function automatic cmp_res_t decode_cascade(input logic lt_i,
                                              input logic eq_i,
                                              input logic gt_i);
    cmp_res_t res;
    res = '0;
    if (eq_i || (!lt_i && !gt_i)) begin
      res.eq = 1'b1;
    end else if (gt_i) begin
      res.gt = 1'b1;
    end else begin
      res.lt = 1'b1;
    end
    return res;
  endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_slice.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_slice
//  Description : Combinational unsigned compare of one SLICE-bit chunk.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o,
  output logic             gt_o
);

  // Plain unsigned relational compare; sign handling is done upstream.
  always_comb begin
    lt_o = (a_i <  b_i);
    eq_o = (a_i == b_i);
    gt_o = (a_i >  b_i);
  end

endmodule : cmp_slice
`default_nettype wire

// File: rtl/seq_mag_compare.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mag_compare
//  Description : Multi-cycle, cascadable magnitude comparator. Walks the
//                operands MSB-first one slice per cycle, stops at the first
//                differing slice, and falls back to the cascade input when
//                all slices match. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic             in_casc_lt,
  input  logic             in_casc_eq,
  input  logic             in_casc_gt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_width
    $error("seq_mag_compare: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  cmp_res_t         casc_q;
  cmp_res_t         res_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] sign_mask_d;
  logic [WIDTH-1:0] a_sh_d;
  logic [WIDTH-1:0] b_sh_d;
  logic [SLICE-1:0] slice_a_d;
  logic [SLICE-1:0] slice_b_d;
  logic             slice_lt_d;
  logic             slice_eq_d;
  logic             slice_gt_d;
  logic             accept_d;

  // In DONE a new operand pair may enter in the same cycle the result leaves.
  assign in_ready = !rst && ((state_q == IDLE) ||
                             ((state_q == DONE) && out_ready));
  assign accept_d = in_valid && in_ready;

  // Flipping the sign bit of both operands turns a two's-complement compare
  // into an unsigned one; storing flipped operands keeps the datapath unsigned.
  assign sign_mask_d = WIDTH'(in_signed) << (WIDTH - 1);

  // Select the slice under test from the latched operands.
  always_comb begin
    a_sh_d    = a_q >> (int'(idx_q) * SLICE);
    b_sh_d    = b_q >> (int'(idx_q) * SLICE);
    slice_a_d = a_sh_d[SLICE-1:0];
    slice_b_d = b_sh_d[SLICE-1:0];
  end

  cmp_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a_i  (slice_a_d),
    .b_i  (slice_b_d),
    .lt_o (slice_lt_d),
    .eq_o (slice_eq_d),
    .gt_o (slice_gt_d)
  );

  // Control FSM, operand capture and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      casc_q      <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= IDLE;
        end
        RUN: begin
          if (!slice_eq_d) begin
            res_q       <= cmp_res_t'{lt: slice_lt_d, eq: 1'b0, gt: slice_gt_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (idx_q == '0) begin
            res_q       <= casc_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // A transfer always wins: it restarts the walk from the top slice.
      if (accept_d) begin
        a_q     <= in_a ^ sign_mask_d;
        b_q     <= in_b ^ sign_mask_d;
        casc_q  <= decode_cascade(in_casc_lt, in_casc_eq, in_casc_gt);
        idx_q   <= IDX_TOP;
        state_q <= RUN;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_lt    = res_q.lt;
  assign out_eq    = res_q.eq;
  assign out_gt    = res_q.gt;

endmodule : seq_mag_compare
`default_nettype wire

// File: tb/tb_seq_mag_compare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mag_compare
//  Description : Directed self-checking bench for seq_mag_compare
//                (WIDTH=16, SLICE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mag_compare;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        in_casc_lt = 1'b0;
  logic        in_casc_eq = 1'b0;
  logic        in_casc_gt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_lt;
  logic        out_eq;
  logic        out_gt;

  int checks   = 0;
  int failures = 0;

  seq_mag_compare #(.WIDTH(16), .SLICE(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .in_casc_lt (in_casc_lt),
    .in_casc_eq (in_casc_eq),
    .in_casc_gt (in_casc_gt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lt     (out_lt),
    .out_eq     (out_eq),
    .out_gt     (out_gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands and let the next rising edge accept them.
  task automatic start(input logic [15:0] a, input logic [15:0] b,
                       input logic sgn, input logic [2:0] casc);
    in_a       = a;
    in_b       = b;
    in_signed  = sgn;
    in_casc_lt = casc[2];
    in_casc_eq = casc[1];
    in_casc_gt = casc[0];
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid, then check result.
  task automatic wait_res(input string tag, input logic [2:0] exp_res, input int exp_lat);
    int lat;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, {out_lt, out_eq, out_gt}, exp_res);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, out_valid, 0);
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sgn, input logic [2:0] casc,
                         input logic [2:0] exp_res, input int exp_lat);
    check({tag, "_rdy"}, in_ready, 1);
    start(a, b, sgn, casc);
    wait_res(tag, exp_res, exp_lat);
    release_out(tag);
  endtask

  initial begin
    // Reset state (result vector ordering is {lt,eq,gt}).
    #12;
    check("rst_rdy", in_ready, 0);
    check("rst_vld", out_valid, 0);
    check("rst_res", {out_lt, out_eq, out_gt}, 3'b000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Equal operands fall through to cascade gt after all four slices.
    run_cmp("eq_casc_gt", 16'h1234, 16'h1234, 1'b0, 3'b001, 3'b001, 4);
    // Top slice decides immediately; signed flips the answer.
    run_cmp("uns_8000",   16'h8000, 16'h7FFF, 1'b0, 3'b010, 3'b001, 1);
    run_cmp("sgn_8000",   16'h8000, 16'h7FFF, 1'b1, 3'b010, 3'b100, 1);
    run_cmp("uns_lsb",    16'h0001, 16'h0002, 1'b0, 3'b010, 3'b100, 4);
    run_cmp("sgn_m1",     16'hFFFF, 16'h0000, 1'b1, 3'b010, 3'b100, 1);

    // Backpressure: result held, no accept, then hand-over in one cycle.
    start(16'h5000, 16'h4000, 1'b0, 3'b010);
    wait_res("bp_first", 3'b001, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_vld", out_valid, 1);
      check("bp_hold_res", {out_lt, out_eq, out_gt}, 3'b001);
      check("bp_hold_rdy", in_ready, 0);
    end
    in_a       = 16'h00F0;
    in_b       = 16'h0F00;
    in_signed  = 1'b0;
    in_casc_lt = 1'b0;
    in_casc_eq = 1'b1;
    in_casc_gt = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    check("bp_handover_rdy", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_after_vld", out_valid, 0);
    check("bp_after_rdy", in_ready, 0);
    wait_res("bp_second", 3'b100, 2);
    release_out("bp_second");

    // Reset in the second RUN cycle; outputs (still holding lt) must clear.
    check("rstrun_rdy0", in_ready, 1);
    start(16'h1234, 16'h1234, 1'b0, 3'b001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rstrun_vld", out_valid, 0);
    check("rstrun_res", {out_lt, out_eq, out_gt}, 3'b000);
    check("rstrun_rdy", in_ready, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("rstrun_nothing", out_valid, 0);
    end
    run_cmp("post_rst", 16'h0001, 16'h0002, 1'b0, 3'b010, 3'b100, 4);

    // Cascade decode corner cases.
    run_cmp("casc_zero", 16'hABCD, 16'hABCD, 1'b0, 3'b000, 3'b010, 4);
    run_cmp("casc_ltgt", 16'hABCD, 16'hABCD, 1'b0, 3'b101, 3'b001, 4);
    run_cmp("casc_lt",   16'h0000, 16'h0000, 1'b1, 3'b100, 3'b100, 4);
    run_cmp("mid_gt",    16'h12A4, 16'h1294, 1'b0, 3'b010, 3'b001, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_mag_compare
`default_nettype wire
